// File: rtl/dff_bank_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dff_bank_rr_arbiter
// Brief    : Round-robin arbiter sharing one WIDTH-bit register among NREQ
//            requesters, with owner lock bursts bounded by MAX_HOLD.
// Revision : 1.0 - initial release
// ============================================================================
module dff_bank_rr_arbiter #(
  parameter  int NREQ     = 4,
  parameter  int WIDTH    = 8,
  parameter  int MAX_HOLD = 4,
  localparam int IDXW     = $clog2(NREQ),
  localparam int HCW      = ((IDXW + 1) > $clog2(MAX_HOLD + 1)) ? (IDXW + 1)
                                                                 : $clog2(MAX_HOLD + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         lock,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  output logic [NREQ-1:0]         grant,
  output logic [WIDTH-1:0]        q,
  output logic                    q_valid,
  output logic [IDXW-1:0]         owner,
  output logic [HCW-1:0]          hold_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  localparam logic [HCW-1:0]  c_max_hold  = HCW'(MAX_HOLD);
  localparam logic [IDXW-1:0] c_owner_rst = IDXW'(NREQ - 1);
  localparam logic [IDXW:0]   c_nreq      = (IDXW + 1)'(NREQ);

  state_t           r_state,    w_state_nxt;
  logic [NREQ-1:0]  r_grant,    w_grant_nxt;
  logic [WIDTH-1:0] r_q,        w_q_nxt;
  logic             r_q_valid,  w_q_valid_nxt;
  logic [IDXW-1:0]  r_owner,    w_owner_nxt;
  logic [HCW-1:0]   r_hold_cnt, w_hold_cnt_nxt;

  logic             w_any_req;
  logic             w_lock_hit;
  logic             w_rr_found;
  logic [IDXW-1:0]  w_rr_idx;
  logic [IDXW:0]    w_sum;
  logic [IDXW-1:0]  w_winner;
  logic [WIDTH-1:0] w_sel_data;

  assign w_any_req  = |req;
  assign w_lock_hit = req[r_owner] & lock[r_owner] &
                      (r_hold_cnt < c_max_hold) & (r_state != S_IDLE);

  // Search owner+1 .. owner+NREQ (mod NREQ); the owner itself is tried last.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = r_owner;
    w_sum      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_sum = {1'b0, r_owner} + (IDXW + 1)'(k);
      if (w_sum >= c_nreq) begin
        w_sum = w_sum - c_nreq;
      end
      if (!w_rr_found && req[w_sum[IDXW-1:0]]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_sum[IDXW-1:0];
      end
    end
  end

  assign w_winner = w_lock_hit ? r_owner : w_rr_idx;

  // Select only the winner's slice so unknowns elsewhere never reach q.
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_winner == IDXW'(i)) begin
        w_sel_data = wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_q_nxt        = r_q;
    w_q_valid_nxt  = r_q_valid;
    w_owner_nxt    = r_owner;
    w_hold_cnt_nxt = r_hold_cnt;
    if (!w_any_req) begin
      w_state_nxt    = S_IDLE;
      w_grant_nxt    = '0;
      w_q_valid_nxt  = 1'b0;
      w_hold_cnt_nxt = '0;
    end else begin
      w_grant_nxt           = '0;
      w_grant_nxt[w_winner] = 1'b1;
      w_q_nxt               = w_sel_data;
      w_q_valid_nxt         = 1'b1;
      w_owner_nxt           = w_winner;
      if (w_lock_hit) begin
        w_state_nxt    = S_LOCKED;
        w_hold_cnt_nxt = r_hold_cnt + HCW'(1);
      end else begin
        w_state_nxt = S_GRANT;
        if (w_rr_idx == r_owner) begin
          w_hold_cnt_nxt = HCW'(1);
        end else begin
          w_hold_cnt_nxt = {{(HCW-1){1'b0}}, lock[w_rr_idx]};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_q        <= '0;
      r_q_valid  <= 1'b0;
      r_owner    <= c_owner_rst;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_q        <= w_q_nxt;
      r_q_valid  <= w_q_valid_nxt;
      r_owner    <= w_owner_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  assign grant    = r_grant;
  assign q        = r_q;
  assign q_valid  = r_q_valid;
  assign owner    = r_owner;
  assign hold_cnt = r_hold_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dff_bank_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dff_bank_rr_arbiter
// Brief    : Directed self-checking bench for dff_bank_rr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dff_bank_rr_arbiter;

  localparam int NREQ     = 4;
  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       lock;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       grant;
  logic [WIDTH-1:0]      q;
  logic                  q_valid;
  logic [1:0]            owner;
  logic [2:0]            hold_cnt;

  int n_checks = 0;
  int n_errs   = 0;

  dff_bank_rr_arbiter #(
    .NREQ     (NREQ),
    .WIDTH    (WIDTH),
    .MAX_HOLD (MAX_HOLD)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .lock     (lock),
    .wdata    (wdata),
    .grant    (grant),
    .q        (q),
    .q_valid  (q_valid),
    .owner    (owner),
    .hold_cnt (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [7:0] d,
                         input logic v, input logic [1:0] o, input logic [2:0] h);
    chk({tag, "_grant"}, 32'(grant), 32'(g));
    chk({tag, "_q"}, 32'(q), 32'(d));
    chk({tag, "_qvalid"}, 32'(q_valid), 32'(v));
    chk({tag, "_owner"}, 32'(owner), 32'(o));
    chk({tag, "_hold"}, 32'(hold_cnt), 32'(h));
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    lock  = '0;
    wdata = '0;
    tick();
    tick();
    chk_all("reset", 4'b0000, 8'h00, 1'b0, 2'd3, 3'd0);
    rst_n = 1'b1;

    // Single requester; other slices unknown
    req   = 4'b0001;
    wdata = {8'hxx, 8'hxx, 8'hxx, 8'hA5};
    tick();
    chk_all("single", 4'b0001, 8'hA5, 1'b1, 2'd0, 3'd0);
    req = 4'b0000;
    tick();
    chk_all("single_drop", 4'b0000, 8'hA5, 1'b0, 2'd0, 3'd0);

    // Fresh reset between edges, then round-robin fairness
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    req   = 4'b1111;
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr_grant", 32'(grant), 32'(1 << (i % 4)));
      chk("rr_q", 32'(q), 32'(8'h11 * ((i % 4) + 1)));
      chk("rr_hold", 32'(hold_cnt), 32'd0);
    end

    // Lock burst: owner 3 -> requester 0 locks for MAX_HOLD grants
    req   = 4'b0011;
    lock  = 4'b0001;
    wdata = {8'h00, 8'h00, 8'hBB, 8'hA0};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_all("lock_burst", 4'b0001, 8'hA0, 1'b1, 2'd0, 3'(i + 1));
    end
    tick();
    chk_all("lock_release", 4'b0010, 8'hBB, 1'b1, 2'd1, 3'd0);
    tick();
    chk_all("lock_back", 4'b0001, 8'hA0, 1'b1, 2'd0, 3'd1);
    tick();
    chk("lock_mid_hold", 32'(hold_cnt), 32'd2);

    // Asynchronous reset mid-burst, checked before any further edge
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_reset", 4'b0000, 8'h00, 1'b0, 2'd3, 3'd0);
    req  = 4'b0000;
    lock = 4'b0000;
    #1 rst_n = 1'b1;

    // Lone owner hits hold limit and restarts at 1
    req   = 4'b0100;
    lock  = 4'b0100;
    wdata = {8'h00, 8'hC3, 8'h00, 8'h00};
    begin
      automatic logic [2:0] exp_h [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd2};
      for (int i = 0; i < 6; i++) begin
        tick();
        chk_all("hold_limit", 4'b0100, 8'hC3, 1'b1, 2'd2, exp_h[i]);
      end
    end

    // Wrap-around and idle
    req   = 4'b1000;
    lock  = 4'b0000;
    wdata = {8'hD3, 8'h00, 8'h00, 8'hD0};
    tick();
    chk_all("wrap_setup", 4'b1000, 8'hD3, 1'b1, 2'd3, 3'd0);
    req = 4'b1001;
    tick();
    chk_all("wrap", 4'b0001, 8'hD0, 1'b1, 2'd0, 3'd0);
    req = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_all("idle", 4'b0000, 8'hD0, 1'b0, 2'd0, 3'd0);
    end
    req = 4'b1001;
    tick();
    chk_all("after_idle", 4'b1000, 8'hD3, 1'b1, 2'd3, 3'd0);

    // Lock from a non-owner is ignored
    req  = 4'b1001;
    lock = 4'b0001;
    tick();
    chk_all("nonowner_lock", 4'b0001, 8'hD0, 1'b1, 2'd0, 3'd1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dff_bank_rr_arbiter.md
Name: dff_bank_rr_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit rising-edge D-register between NREQ requesters.
- Each cycle it picks one requester and loads that requester's data into the shared register.
- It reports the winner with a registered one-hot grant and an owner index.
- A per-requester lock lets the current owner keep the register for short bursts. A hold limit bounds the burst so no requester starves.

Parameters:
NREQ, 4, number of requesters (2..16)
WIDTH, 8, data width of the shared register
MAX_HOLD, 4, maximum consecutive locked grants to one owner (>=1)
IDXW, $clog2(NREQ), width of owner index (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  NREQ  per-requester write request, level-sensitive
lock  input  NREQ  per-requester burst lock, meaningful only for the current owner
wdata  input  NREQ*WIDTH  requester data, slice i = wdata[i*WIDTH +: WIDTH]
grant  output  NREQ  registered one-hot; bit i high = wdata[i] captured at the last edge
q  output  WIDTH  shared register contents
q_valid  output  1  high for exactly the cycles in which q was written at the preceding edge
owner  output  IDXW  index of the last winner; holds when idle
hold_cnt  output  IDXW+1 (min $clog2(MAX_HOLD+1))  consecutive locked grants to owner

Behaviour:
- Reset: clk is one clock; rst_n is an asynchronous, active-low reset.
- Reset values: grant=0, q=0, q_valid=0, owner=NREQ-1, hold_cnt=0, state=IDLE. Because owner=NREQ-1, requester 0 has top priority on the first arbitration.
- Reset mid-operation: takes effect immediately regardless of clk. Any in-progress burst is discarded.
- All outputs are registered. Latency: req/wdata sampled at edge k, so grant/q/q_valid/owner are visible during cycle k+1 (1 cycle).
- States:
  - IDLE: last edge had no req.
  - GRANT: last edge made a round-robin grant.
  - LOCKED: last edge re-granted the owner under lock.
- Arbitration at each edge, with any(req) = |req:
  - any(req)=0: goto IDLE. grant<=0, q_valid<=0, q and owner hold, hold_cnt<=0.
  - Lock path, when req[owner] & lock[owner] & hold_cnt<MAX_HOLD & state!=IDLE: winner=owner, goto LOCKED, hold_cnt<=hold_cnt+1.
  - Otherwise round-robin: winner = first i with req[i]=1, searching owner+1, owner+2, ... modulo NREQ, wrapping past NREQ-1 to 0.
    - If winner==owner (only the owner is requesting), hold_cnt<=1.
    - Otherwise hold_cnt<=1 if lock[winner] else 0.
    - Goto GRANT.
  - On any win: grant<=onehot(winner), q<=wdata[winner], q_valid<=1, owner<=winner.
- Hold limit: once hold_cnt==MAX_HOLD, the next arbitration is round-robin from owner+1. If no other requester is asserting, the owner wins again with hold_cnt<=1.
- Lock without req is ignored. Lock asserted by a non-owner has no effect on arbitration.
- Handshake: req is level. grant[i] in cycle k+1 acknowledges capture of the data sampled at edge k. Keeping req[i] high in cycle k+1 is a new request. No request is ever queued or dropped silently: an unserved req simply competes again.
- Simultaneous requests: exactly one grant bit high per cycle. Ordering is strictly round-robin from owner+1.
- X on wdata of non-winners must not propagate to q.

Test Plan:
1. Reset: assert rst_n=0 mid-burst with no clk edge -> grant=0, q=0, q_valid=0, owner=3, hold_cnt=0 immediately.
2. Single requester: req=0001, wdata[0]=8'hA5 at edge 1 -> cycle 2 has grant=0001, q=8'hA5, q_valid=1, owner=0. Drop req -> next cycle grant=0, q_valid=0, q=8'hA5 holds.
3. Round-robin fairness: req=1111 held 8 cycles, no lock -> grant sequence 0001,0010,0100,1000,0001,0010,0100,1000. q follows wdata[0..3]=11,22,33,44 in that order.
4. Lock burst: req=0011, lock=0001, MAX_HOLD=4, wdata[1]=8'hBB -> grant=0001 for 4 cycles with hold_cnt=1,2,3,4, then 0010 with q=8'hBB, then 0001 again.
5. Hold-limit, lone owner: req=0100, lock=0100 for 6 cycles -> grant=0100 every cycle; hold_cnt=1,2,3,4,1,2.
6. Wrap-around and idle: owner=3, then req=1001 -> winner 0. Then req=0000 for 2 cycles, then req=1001 -> winner 3 (search from owner 0 + 1), with owner held through idle.
